// File: rtl/deploy_ctrl.sv
// Card deploy controller: arm a hand slot, validate a click, spend elixir, spawn a troop, rotate the deck.
// Latency: click to elixir_spend pulse is 2 cycles; spawn_valid is presented on the cycle after the spend.
// Backpressure: spawn_valid holds with stable card/position until spawn_ready; the deck rotates only on that cycle.
// Optional post-deploy lockout is compiled in with DEPLOY_CTRL_COOLDOWN_EN.
module deploy_ctrl #(
  parameter int COOLDOWN_CYC = 30,
  parameter int MIN_Y        = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        game_active,
  input  logic        key_valid,
  input  logic [1:0]  key_slot,
  input  logic        place_valid,
  input  logic [9:0]  place_x,
  input  logic [9:0]  place_y,
  input  logic [4:0]  elixir_avail,
  output logic [4:0]  elixir_spend,
  output logic        spawn_valid,
  input  logic        spawn_ready,
  output logic [2:0]  spawn_card,
  output logic [9:0]  spawn_x,
  output logic [9:0]  spawn_y,
  output logic [11:0] hand,
  output logic [2:0]  next_card,
  output logic        sel_valid,
  output logic [1:0]  sel_slot,
  output logic        reject
);

  localparam logic [9:0] MIN_Y_V = 10'(MIN_Y);
  localparam logic [9:0] MAX_X_V = 10'd639;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CHECK,
    ST_SPEND,
    ST_SPAWN
`ifdef DEPLOY_CTRL_COOLDOWN_EN
    , ST_COOLDOWN
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  slot_q, slot_d;
  logic [9:0]  px_q, px_d;
  logic [9:0]  py_q, py_d;
  logic [2:0]  hand_q [4];
  logic [2:0]  queue_q [4];
  logic [1:0]  head_q;
  logic        xfer;
  logic [2:0]  cost;
  logic        place_ok;

`ifdef DEPLOY_CTRL_COOLDOWN_EN
  localparam int CW = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  function automatic logic [2:0] card_cost(input logic [2:0] id);
    logic [2:0] c;
    case (id)
      3'd0: c = 3'd3;
      3'd1: c = 3'd4;
      3'd2: c = 3'd5;
      3'd3: c = 3'd2;
      3'd4: c = 3'd6;
      3'd5: c = 3'd3;
      3'd6: c = 3'd4;
      default: c = 3'd7;
    endcase
    return c;
  endfunction

  assign spawn_card = hand_q[slot_q];
  assign spawn_x    = px_q;
  assign spawn_y    = py_q;
  assign sel_slot   = slot_q;
  assign hand       = {hand_q[3], hand_q[2], hand_q[1], hand_q[0]};
  assign next_card  = queue_q[head_q];
  assign cost       = card_cost(spawn_card);
  assign place_ok   = ({2'b00, cost} <= elixir_avail) && (py_q >= MIN_Y_V) && (px_q <= MAX_X_V);

  // Next-state and Moore outputs; a stopped match overrides every state.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    px_d         = px_q;
    py_d         = py_q;
    elixir_spend = 5'd0;
    spawn_valid  = 1'b0;
    sel_valid    = 1'b0;
    reject       = 1'b0;
    xfer         = 1'b0;
`ifdef DEPLOY_CTRL_COOLDOWN_EN
    cnt_d        = cnt_q;
`endif
    if (!game_active) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_valid) begin
            slot_d  = key_slot;
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          sel_valid = 1'b1;
          if (place_valid) begin
            px_d    = place_x;
            py_d    = place_y;
            state_d = ST_CHECK;
          end else if (key_valid) begin
            if (key_slot == slot_q) state_d = ST_IDLE;
            else                    slot_d  = key_slot;
          end
        end
        ST_CHECK: begin
          sel_valid = 1'b1;
          if (place_ok) begin
            state_d = ST_SPEND;
          end else begin
            reject  = 1'b1;
            state_d = ST_ARMED;
          end
        end
        ST_SPEND: begin
          sel_valid    = 1'b1;
          // 3*cost = 2*cost + cost; max 21 fits in 5 bits
          elixir_spend = {1'b0, cost, 1'b0} + {2'b00, cost};
          state_d      = ST_SPAWN;
        end
        ST_SPAWN: begin
          sel_valid   = 1'b1;
          spawn_valid = 1'b1;
          if (spawn_ready) begin
            xfer = 1'b1;
`ifdef DEPLOY_CTRL_COOLDOWN_EN
            cnt_d   = CW'(COOLDOWN_CYC - 1);
            state_d = ST_COOLDOWN;
`else
            state_d = ST_IDLE;
`endif
          end
        end
`ifdef DEPLOY_CTRL_COOLDOWN_EN
        ST_COOLDOWN: begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control registers: FSM state, armed slot, latched click position.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      slot_q  <= 2'd0;
      px_q    <= 10'd0;
      py_q    <= 10'd0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end
  end

  // Deck rotation: armed slot takes the queue head, used card lands in the freed tail entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        hand_q[i]  <= 3'(i);
        queue_q[i] <= 3'(i + 4);
      end
      head_q <= 2'd0;
    end else if (xfer) begin
      hand_q[slot_q]  <= queue_q[head_q];
      queue_q[head_q] <= hand_q[slot_q];
      head_q          <= head_q + 2'd1;
    end
  end

`ifdef DEPLOY_CTRL_COOLDOWN_EN
  // Lockout counter, loaded on transfer and run down in COOLDOWN.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

endmodule
